// File: rtl/mac_spd_pkg.sv
// mac_spd_pkg
// Shared types and constants for the MAC run-time speed controller.
//   spd_e   : link speed codes (10M / 100M / 1000M / reserved)
//   state_e : speed-change sequencer states
//   spd2div : maps a speed code to hclk_i cycles per datapath clock-enable
package mac_spd_pkg;

    typedef enum logic [1:0] {
        SPD_10M  = 2'd0,
        SPD_100M = 2'd1,
        SPD_1G   = 2'd2,
        SPD_RSVD = 2'd3
    } spd_e;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        SWITCH = 2'd2,
        SETTLE = 2'd3
    } state_e;

    // Divider counter width; the largest legal divider is 63.
    localparam int unsigned CNT_W = 6;

    localparam int unsigned DIV_10M_DEF  = 50;
    localparam int unsigned DIV_100M_DEF = 5;
    localparam int unsigned DIV_1G_DEF   = 1;

    // The reserved code is never loaded as the active speed, so it shares the 1G entry.
    function automatic logic [CNT_W-1:0] spd2div(
        input spd_e        spd,
        input int unsigned d10  = DIV_10M_DEF,
        input int unsigned d100 = DIV_100M_DEF,
        input int unsigned d1g  = DIV_1G_DEF
    );
        logic [CNT_W-1:0] div;
        case (spd)
            SPD_10M:  div = CNT_W'(d10);
            SPD_100M: div = CNT_W'(d100);
            default:  div = CNT_W'(d1g);
        endcase
        return div;
    endfunction

endpackage

// File: rtl/mac_ce_div.sv
// mac_ce_div
// Clock-enable divider: counts 0..div_i-1 while running and flags the last count.
//   clk_i   : host clock
//   rst_ni  : synchronous active-low reset
//   div_i   : hclk_i cycles per enable (1 gives a constant enable)
//   clear_i : force the counter to zero
//   run_i   : counting allowed; when low the counter is held at zero
//   ce_o    : enable pulse, decoded from the registered count
module mac_ce_div
    import mac_spd_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [CNT_W-1:0] div_i,
    input  logic             clear_i,
    input  logic             run_i,
    output logic             ce_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap;

    assign wrap = (cnt_q == (div_i - CNT_W'(1)));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !run_i) begin
            cnt_d = '0;
        end else if (wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ce_o = run_i && wrap;

endmodule

// File: rtl/mac_speed_ctrl.sv
// mac_speed_ctrl
// Run-time speed controller for the MAC TX/RX datapath. Generates the per-speed
// clock-enables and sequences speed changes: hold off new frames, drain the
// in-flight frame (with timeout), switch the divider, settle, then acknowledge.
//   hclk_i     : 125 MHz host clock
//   hrst_n_i   : synchronous active-low reset
//   spd_req_i  : speed-change request level, held until spd_ack_o
//   spd_sel_i  : requested speed code (3 is reserved and rejected)
//   tx_busy_i  : datapath has a frame in flight
//   spd_ack_o  : one-cycle acknowledge
//   spd_err_o  : one-cycle reject flag, coincident with spd_ack_o
//   tmo_o      : one-cycle pulse when a drain timeout forces the switch
//   spd_cur_o  : active speed code
//   tx_hold_o  : datapath must not start a new frame
//   tx_ce_o    : TX clock-enable
//   rx_ce_o    : RX clock-enable, same timing as tx_ce_o
//   link_rdy_o : high only while running normally
module mac_speed_ctrl
    import mac_spd_pkg::*;
#(
    parameter int unsigned DIV_10M    = DIV_10M_DEF,
    parameter int unsigned DIV_100M   = DIV_100M_DEF,
    parameter int unsigned DIV_1G     = DIV_1G_DEF,
    parameter int unsigned SETTLE_CYC = 16,
    parameter int unsigned DRAIN_TMO  = 65535,
    parameter logic [1:0]  RST_SPD    = 2'd0
) (
    input  logic       hclk_i,
    input  logic       hrst_n_i,
    input  logic       spd_req_i,
    input  logic [1:0] spd_sel_i,
    input  logic       tx_busy_i,
    output logic       spd_ack_o,
    output logic       spd_err_o,
    output logic       tmo_o,
    output logic [1:0] spd_cur_o,
    output logic       tx_hold_o,
    output logic       tx_ce_o,
    output logic       rx_ce_o,
    output logic       link_rdy_o
);

    state_e           state_q;
    spd_e             spd_cur_q;
    spd_e             sel_q;
    logic [7:0]       settle_cnt_q;
    logic [15:0]      drain_cnt_q;
    logic             rearm_q;
    logic             ack_pend_q;
    logic             ack_q;
    logic             err_q;
    logic             tmo_q;
    logic             hold_q;
    logic             rdy_q;
    logic [CNT_W-1:0] div;
    logic             ce_run;
    logic             ce_clr;
    logic             ce;

    always_ff @(posedge hclk_i) begin
        if (!hrst_n_i) begin
            state_q      <= SETTLE;
            spd_cur_q    <= spd_e'(RST_SPD);
            sel_q        <= spd_e'(RST_SPD);
            settle_cnt_q <= '0;
            drain_cnt_q  <= '0;
            rearm_q      <= 1'b1;
            ack_pend_q   <= 1'b0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            tmo_q        <= 1'b0;
            hold_q       <= 1'b1;
            rdy_q        <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            tmo_q <= 1'b0;
            // A request is only taken again after the requester has been seen low.
            if (!spd_req_i) begin
                rearm_q <= 1'b1;
            end
            unique case (state_q)
                RUN: begin
                    if (spd_req_i && rearm_q) begin
                        if (spd_sel_i == SPD_RSVD) begin
                            ack_q   <= 1'b1;
                            err_q   <= 1'b1;
                            rearm_q <= 1'b0;
                        end else if (spd_sel_i == spd_cur_q) begin
                            ack_q   <= 1'b1;
                            rearm_q <= 1'b0;
                        end else begin
                            sel_q       <= spd_e'(spd_sel_i);
                            drain_cnt_q <= '0;
                            ack_pend_q  <= 1'b1;
                            hold_q      <= 1'b1;
                            rdy_q       <= 1'b0;
                            state_q     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // tmo_q high means the timeout pulse is showing this cycle.
                    if (!tx_busy_i || tmo_q) begin
                        spd_cur_q <= sel_q;
                        state_q   <= SWITCH;
                    end else if (drain_cnt_q == 16'(DRAIN_TMO - 1)) begin
                        tmo_q <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 16'd1;
                    end
                end
                SWITCH: begin
                    settle_cnt_q <= '0;
                    state_q      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt_q == 8'(SETTLE_CYC - 1)) begin
                        state_q <= RUN;
                        hold_q  <= 1'b0;
                        rdy_q   <= 1'b1;
                        // The settle that follows reset is not acknowledged.
                        if (ack_pend_q) begin
                            ack_q      <= 1'b1;
                            rearm_q    <= 1'b0;
                            ack_pend_q <= 1'b0;
                        end
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 8'd1;
                    end
                end
            endcase
        end
    end

    // Enables keep running through DRAIN so the in-flight frame can finish.
    assign ce_run = (state_q == RUN) || (state_q == DRAIN);
    assign ce_clr = (state_q == SWITCH);
    assign div    = spd2div(spd_cur_q, DIV_10M, DIV_100M, DIV_1G);

    mac_ce_div u_ce_div (
        .clk_i   (hclk_i),
        .rst_ni  (hrst_n_i),
        .div_i   (div),
        .clear_i (ce_clr),
        .run_i   (ce_run),
        .ce_o    (ce)
    );

    assign spd_ack_o  = ack_q;
    assign spd_err_o  = err_q;
    assign tmo_o      = tmo_q;
    assign spd_cur_o  = spd_cur_q;
    assign tx_hold_o  = hold_q;
    assign link_rdy_o = rdy_q;
    assign tx_ce_o    = ce;
    assign rx_ce_o    = ce;

endmodule

// File: tb/tb_mac_speed_ctrl.sv
// tb_mac_speed_ctrl
// Randomised scoreboard bench for mac_speed_ctrl. The stimulus process computes
// the expected timeline of each request (ack cycle, timeout cycle, hold / ready /
// enable windows) and queues it; a negedge monitor compares every cycle.
module tb_mac_speed_ctrl;

    localparam int TMO    = 20;
    localparam int SETTLE = 16;

    logic       hclk = 1'b0;
    logic       hrst_n = 1'b0;
    logic       req = 1'b0;
    logic [1:0] sel = 2'd0;
    logic       busy = 1'b0;
    logic       ack, err, tmo, hold, tx_ce, rx_ce, rdy;
    logic [1:0] cur;

    mac_speed_ctrl #(
        .SETTLE_CYC (SETTLE),
        .DRAIN_TMO  (TMO)
    ) dut (
        .hclk_i     (hclk),
        .hrst_n_i   (hrst_n),
        .spd_req_i  (req),
        .spd_sel_i  (sel),
        .tx_busy_i  (busy),
        .spd_ack_o  (ack),
        .spd_err_o  (err),
        .tmo_o      (tmo),
        .spd_cur_o  (cur),
        .tx_hold_o  (hold),
        .tx_ce_o    (tx_ce),
        .rx_ce_o    (rx_ce),
        .link_rdy_o (rdy)
    );

    always #4 hclk = ~hclk;

    int cyc = 0;
    always @(posedge hclk) cyc <= cyc + 1;

    // A stretch of cycles with fixed expected outputs; enables pulse every div
    // cycles counted from base when ce_on is set.
    typedef struct {
        int start;
        bit hold;
        bit link;
        bit ce_on;
        int base;
        int div;
        int spd;
    } seg_t;

    typedef struct {
        int cyc;
        bit err;
        int spd;
    } ack_t;

    seg_t seg_q[$];
    ack_t ack_q[$];
    int   tmo_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    int m_spd = 0;  // model: active speed
    int m_run = 0;  // model: cycle at which the current run stretch began

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int div_of(input int s);
        return (s == 0) ? 50 : ((s == 1) ? 5 : 1);
    endfunction

    task automatic push_seg(input seg_t s);
        while (seg_q.size() > 0 && seg_q[$].start >= s.start) void'(seg_q.pop_back());
        seg_q.push_back(s);
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    // Assert reset for hold_cyc sampled edges; everything after the first of
    // them is replaced by the reset timeline.
    task automatic do_reset(input int hold_cyc);
        seg_t sg;
        int   r;
        hrst_n = 1'b0;
        req    = 1'b0;
        busy   = 1'b0;
        r      = cyc + 1;
        sg     = '{r, 1'b1, 1'b0, 1'b0, 0, 1, 0};
        push_seg(sg);
        while (ack_q.size() > 0 && ack_q[$].cyc >= r) void'(ack_q.pop_back());
        while (tmo_q.size() > 0 && tmo_q[$] >= r) void'(tmo_q.pop_back());
        repeat (hold_cyc) tick();
        hrst_n = 1'b1;
        m_spd  = 0;
        m_run  = cyc + SETTLE;
        sg     = '{m_run, 1'b0, 1'b1, 1'b1, m_run, div_of(0), 0};
        push_seg(sg);
    endtask

    // One request. bt: cycles busy stays high from the request cycle on.
    // extra: cycles req is held past the ack. abort >= 0: reset that many
    // cycles after the request is driven.
    task automatic do_req(input int s, input int bt, input int extra, input bit scramble,
                          input int abort);
        seg_t sg;
        int   k, e, b, sw, a;
        while (cyc < m_run) tick();
        k    = cyc;
        req  = 1'b1;
        sel  = 2'(s);
        busy = (bt > 0);
        e    = k + 1;
        if (s == 3) begin
            ack_q.push_back('{e, 1'b1, m_spd});
            a = e;
        end else if (s == m_spd) begin
            ack_q.push_back('{e, 1'b0, m_spd});
            a = e;
        end else begin
            b = (bt > 0) ? bt - 1 : 0;
            if (b < TMO) begin
                sw = e + b + 1;
            end else begin
                tmo_q.push_back(e + TMO);
                sw = e + TMO + 1;
            end
            a  = sw + 1 + SETTLE;
            sg = '{e, 1'b1, 1'b0, 1'b1, m_run, div_of(m_spd), m_spd};
            push_seg(sg);
            sg = '{sw, 1'b1, 1'b0, 1'b0, 0, 1, s};
            push_seg(sg);
            sg = '{a, 1'b0, 1'b1, 1'b1, a, div_of(s), s};
            push_seg(sg);
            ack_q.push_back('{a, 1'b0, s});
            m_spd = s;
            m_run = a;
        end
        while (cyc < a + extra) begin
            tick();
            if (abort >= 0 && cyc == k + abort) begin
                do_reset(2);
                return;
            end
            if (cyc >= k + bt) busy = 1'b0;
            if (scramble) sel = 2'($urandom_range(0, 3));
        end
        req  = 1'b0;
        busy = 1'b0;
        tick();
    endtask

    always @(negedge hclk) begin
        bit   exp_ack, exp_tmo;
        ack_t ae;
        seg_t s;
        while (seg_q.size() > 1 && seg_q[1].start <= cyc) void'(seg_q.pop_front());
        if (seg_q.size() > 0 && seg_q[0].start <= cyc) begin
            s = seg_q[0];
            chk("tx_hold_o", int'(hold), int'(s.hold));
            chk("link_rdy_o", int'(rdy), int'(s.link));
            chk("spd_cur_o", int'(cur), s.spd);
            chk("tx_ce_o", int'(tx_ce),
                int'(s.ce_on && (((cyc - s.base + 1) % s.div) == 0)));
            chk("rx_ce_o", int'(rx_ce), int'(tx_ce));
            while (ack_q.size() > 0 && ack_q[0].cyc < cyc) void'(ack_q.pop_front());
            while (tmo_q.size() > 0 && tmo_q[0] < cyc) void'(tmo_q.pop_front());
            exp_ack = (ack_q.size() > 0 && ack_q[0].cyc == cyc);
            exp_tmo = (tmo_q.size() > 0 && tmo_q[0] == cyc);
            chk("spd_ack_o", int'(ack), int'(exp_ack));
            chk("tmo_o", int'(tmo), int'(exp_tmo));
            if (exp_ack) begin
                ae = ack_q.pop_front();
                chk("spd_err_o", int'(err), int'(ae.err));
                chk("spd_cur_at_ack", int'(cur), ae.spd);
            end else begin
                chk("spd_err_o", int'(err), 0);
            end
            if (exp_tmo) void'(tmo_q.pop_front());
        end
    end

    initial begin
        int s, r, bt;
        do_reset(3);
        // Idle at 10M long enough to see several enable pulses.
        while (cyc < m_run + 110) tick();
        do_req(2, 0, 0, 1'b0, -1);        // idle datapath, to 1G
        repeat (10) tick();
        do_req(1, 15, 0, 1'b0, -1);       // drains, no timeout
        repeat (30) tick();
        do_req(0, 1000, 0, 1'b1, -1);     // stuck busy, forced switch
        repeat (60) tick();
        do_req(3, 0, 4, 1'b0, -1);        // reserved, held past ack
        repeat (7) tick();
        do_req(0, 0, 5, 1'b0, -1);        // same speed, held past ack
        repeat (20) tick();
        do_req(1, 1000, 0, 1'b0, 3);      // reset during DRAIN
        repeat (40) tick();
        do_req(2, 0, 0, 1'b0, 10);        // reset during SETTLE
        repeat (30) tick();
        for (int i = 0; i < 30; i++) begin
            s  = $urandom_range(0, 3);
            r  = $urandom_range(0, 9);
            bt = (r < 3) ? 0 : ((r < 8) ? $urandom_range(1, 25) : 1000);
            do_req(s, bt, $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1);
            repeat ($urandom_range(0, 60)) tick();
        end
        repeat (60) tick();
        chk("ack_queue_left", ack_q.size(), 0);
        chk("tmo_queue_left", tmo_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
